// File: rtl/stroke_grid_pkg.sv
// Shared types for the stroke capture front end: FSM states, cell points and
// the adjacency test that decides whether a sample continues the current stroke.
package stroke_grid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_CHECK   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_SHOW    = 3'd4
   } state_t;

   // Wide enough for any grid up to 256 cells per axis.
   localparam int PT_W = 8;

   typedef struct packed {
      logic [PT_W-1:0] x;
      logic [PT_W-1:0] y;
   } cell_pt_t;

   // True when the two cells are not 8-neighbours (or the same cell).
   function automatic logic pt_far(input cell_pt_t a, input cell_pt_t b);
      logic [PT_W-1:0] dx;
      logic [PT_W-1:0] dy;
      dx = (a.x >= b.x) ? (a.x - b.x) : (b.x - a.x);
      dy = (a.y >= b.y) ? (a.y - b.y) : (b.y - a.y);
      return (dx > PT_W'(1)) || (dy > PT_W'(1));
   endfunction

endpackage

// File: rtl/coord_scaler.sv
// Maps one raw touch coordinate onto a grid cell index: (coord*MUL)>>SHIFT,
// clamped to the last cell so out-of-range touches land on the edge.
module coord_scaler #(
   parameter int COORD_W = 12,
   parameter int MUL     = 3,
   parameter int SHIFT   = 10,
   parameter int CELLS   = 12
) (
   input  logic [COORD_W-1:0]        coord_i,
   output logic [$clog2(CELLS)-1:0]  cell_o
);

   localparam int PROD_W = COORD_W + $clog2(MUL + 1);
   localparam int CELL_W = $clog2(CELLS);

   logic [PROD_W-1:0] prod;
   logic [PROD_W-1:0] shifted;

   assign prod    = PROD_W'(coord_i) * PROD_W'(MUL);
   assign shifted = prod >> SHIFT;
   assign cell_o  = (shifted > PROD_W'(CELLS - 1)) ? CELL_W'(CELLS - 1)
                                                   : shifted[CELL_W-1:0];

endmodule

// File: rtl/stroke_grid_capture.sv
// Touch-stroke capture: builds the occupancy bitmap and stroke table during a
// session, then freezes it and hands it to the recogniser via req/result.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | all capture state cleared, waiting for i_session
// ST_CAPTURE | samples update bitmap and stroke table
// ST_CHECK   | one frozen cycle before the recogniser is asked
// ST_WAIT    | o_req high, waiting for i_result_valid
// ST_SHOW    | result latched and displayed until i_clear
module stroke_grid_capture
   import stroke_grid_pkg::*;
#(
   parameter int COORD_W       = 12,
   parameter int GRID_W        = 12,
   parameter int GRID_H        = 8,
   parameter int X_MUL         = 3,
   parameter int X_SHIFT       = 10,
   parameter int Y_MUL         = 1,
   parameter int Y_SHIFT       = 9,
   parameter int MAX_STROKES   = 4,
   parameter int SPLIT_ON_LIFT = 1,
   parameter int RES_W         = 4
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst,
   input  logic                                      i_clear,
   input  logic                                      i_session,
   input  logic                                      i_touch_valid,
   input  logic [COORD_W-1:0]                        i_touch_x,
   input  logic [COORD_W-1:0]                        i_touch_y,
   output logic [$clog2(GRID_W)-1:0]                 o_cell_x,
   output logic [$clog2(GRID_H)-1:0]                 o_cell_y,
   output logic [GRID_W*GRID_H-1:0]                  o_grid,
   output logic [$clog2(MAX_STROKES+1)-1:0]          o_stroke_count,
   output logic [MAX_STROKES*$clog2(GRID_W)-1:0]     o_start_x,
   output logic [MAX_STROKES*$clog2(GRID_H)-1:0]     o_start_y,
   output logic [MAX_STROKES*$clog2(GRID_W)-1:0]     o_end_x,
   output logic [MAX_STROKES*$clog2(GRID_H)-1:0]     o_end_y,
   output logic                                      o_overflow,
   output logic                                      o_req,
   input  logic                                      i_result_valid,
   input  logic [RES_W-1:0]                          i_result,
   output logic [RES_W-1:0]                          o_result,
   output logic                                      o_result_valid
);

   localparam int CX_W  = $clog2(GRID_W);
   localparam int CY_W  = $clog2(GRID_H);
   localparam int CNT_W = $clog2(MAX_STROKES + 1);
   localparam int NCELL = GRID_W * GRID_H;
   localparam int IDX_W = $clog2(NCELL);

   state_t             state_q, state_d;
   logic [NCELL-1:0]   grid_q, grid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [RES_W-1:0]   result_q, result_d;
   cell_pt_t           last_q, last_d;
   logic               prev_valid_q;
   logic [CX_W-1:0]    sx_q [MAX_STROKES];
   logic [CX_W-1:0]    sx_d [MAX_STROKES];
   logic [CY_W-1:0]    sy_q [MAX_STROKES];
   logic [CY_W-1:0]    sy_d [MAX_STROKES];
   logic [CX_W-1:0]    ex_q [MAX_STROKES];
   logic [CX_W-1:0]    ex_d [MAX_STROKES];
   logic [CY_W-1:0]    ey_q [MAX_STROKES];
   logic [CY_W-1:0]    ey_d [MAX_STROKES];

   logic [CX_W-1:0]    cell_x;
   logic [CY_W-1:0]    cell_y;
   logic [IDX_W-1:0]   cell_idx;
   cell_pt_t           cur_pt;
   logic               split;
   logic               wr_start;
   logic [CNT_W-1:0]   wr_idx;

   coord_scaler #(
      .COORD_W (COORD_W),
      .MUL     (X_MUL),
      .SHIFT   (X_SHIFT),
      .CELLS   (GRID_W)
   ) u_scale_x (
      .coord_i (i_touch_x),
      .cell_o  (cell_x)
   );

   coord_scaler #(
      .COORD_W (COORD_W),
      .MUL     (Y_MUL),
      .SHIFT   (Y_SHIFT),
      .CELLS   (GRID_H)
   ) u_scale_y (
      .coord_i (i_touch_y),
      .cell_o  (cell_y)
   );

   assign o_cell_x = cell_x;
   assign o_cell_y = cell_y;
   assign cell_idx = IDX_W'(cell_x) * IDX_W'(GRID_H) + IDX_W'(cell_y);
   assign cur_pt.x = PT_W'(cell_x);
   assign cur_pt.y = PT_W'(cell_y);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (i_clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (i_session) state_d = ST_CAPTURE;
            // cnt_d includes a sample arriving on the same cycle the session ends
            ST_CAPTURE: if (!i_session) state_d = (cnt_d != '0) ? ST_CHECK : ST_IDLE;
            ST_CHECK:   state_d = ST_WAIT;
            ST_WAIT:    if (i_result_valid) state_d = ST_SHOW;
            ST_SHOW:    state_d = ST_SHOW;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_req          = (state_q == ST_WAIT) || (state_q == ST_SHOW);
      o_result_valid = (state_q == ST_SHOW);
   end

   always_comb begin
      grid_d   = grid_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      last_d   = last_q;
      sx_d     = sx_q;
      sy_d     = sy_q;
      ex_d     = ex_q;
      ey_d     = ey_q;
      split    = 1'b0;
      wr_start = 1'b0;
      wr_idx   = '0;

      if (i_clear || state_q == ST_IDLE) begin
         grid_d   = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
         result_d = '0;
         last_d   = '0;
         for (int k = 0; k < MAX_STROKES; k++) begin
            sx_d[k] = '0;
            sy_d[k] = '0;
            ex_d[k] = '0;
            ey_d[k] = '0;
         end
      end else if (state_q == ST_CAPTURE && i_touch_valid) begin
         grid_d[cell_idx] = 1'b1;
         last_d = cur_pt;
         split  = pt_far(cur_pt, last_q) || ((SPLIT_ON_LIFT != 0) && !prev_valid_q);

         if (cnt_q == '0) begin
            wr_idx   = '0;
            wr_start = 1'b1;
            cnt_d    = CNT_W'(1);
         end else if (split && cnt_q < CNT_W'(MAX_STROKES)) begin
            wr_idx   = cnt_q;
            wr_start = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
         end else begin
            // table full (or no split): the sample only moves the last end point
            wr_idx = cnt_q - CNT_W'(1);
            if (split) ovf_d = 1'b1;
         end

         for (int k = 0; k < MAX_STROKES; k++) begin
            if (CNT_W'(k) == wr_idx) begin
               ex_d[k] = cell_x;
               ey_d[k] = cell_y;
               if (wr_start) begin
                  sx_d[k] = cell_x;
                  sy_d[k] = cell_y;
               end
            end
         end
      end else if (state_q == ST_WAIT && i_result_valid) begin
         result_d = i_result;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         grid_q       <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         result_q     <= '0;
         last_q       <= '0;
         prev_valid_q <= 1'b0;
         for (int k = 0; k < MAX_STROKES; k++) begin
            sx_q[k] <= '0;
            sy_q[k] <= '0;
            ex_q[k] <= '0;
            ey_q[k] <= '0;
         end
      end else begin
         grid_q       <= grid_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         result_q     <= result_d;
         last_q       <= last_d;
         prev_valid_q <= i_touch_valid;
         sx_q         <= sx_d;
         sy_q         <= sy_d;
         ex_q         <= ex_d;
         ey_q         <= ey_d;
      end
   end

   for (genvar k = 0; k < MAX_STROKES; k++) begin : g_flat
      assign o_start_x[k*CX_W +: CX_W] = sx_q[k];
      assign o_start_y[k*CY_W +: CY_W] = sy_q[k];
      assign o_end_x[k*CX_W +: CX_W]   = ex_q[k];
      assign o_end_y[k*CY_W +: CY_W]   = ey_q[k];
   end

   assign o_grid         = grid_q;
   assign o_stroke_count = cnt_q;
   assign o_overflow     = ovf_q;
   assign o_result       = result_q;

endmodule

// File: doc/stroke_grid_capture.md
# stroke_grid_capture

Parametrised touch-stroke capture front end for the digit recogniser. It maps raw touchscreen coordinates onto a GRID_W×GRID_H occupancy bitmap and records start/end points for up to MAX_STROKES strokes. It then hands the frozen bitmap to the recogniser with a req/valid handshake and holds the returned class until cleared. It sits between the touch controller interface and the recogniser core.

## Interface
- COORD_W, 12, raw touch coordinate width
- GRID_W, 12, grid columns (x cells)
- GRID_H, 8, grid rows (y cells)
- X_MUL / X_SHIFT, 3 / 10, x cell = (x*X_MUL)>>X_SHIFT, clamped to GRID_W-1
- Y_MUL / Y_SHIFT, 1 / 9, y cell = (y*Y_MUL)>>Y_SHIFT, clamped to GRID_H-1
- MAX_STROKES, 4, stroke table depth (≥1)
- SPLIT_ON_LIFT, 1, 1: pen lift also starts a new stroke; 0: distance rule only
- RES_W, 4, recogniser result width
- Clocking: one clock; reset is asynchronous and active-low. The ports are named i_clk and i_rst.
- i_clk  in  1  clock
- i_rst  in  1  async active-low reset
- i_clear  in  1  abort/restart; returns to IDLE from any state
- i_session  in  1  capture window; high = drawing allowed
- i_touch_valid  in  1  touch sample valid this cycle
- i_touch_x / i_touch_y  in  COORD_W  raw coordinates
- o_cell_x / o_cell_y  out  $clog2(GRID_W) / $clog2(GRID_H)  combinational mapped cell of current input
- o_grid  out  GRID_W*GRID_H  bitmap; bit x*GRID_H+y = cell (x,y)
- o_stroke_count  out  $clog2(MAX_STROKES+1)  strokes recorded
- o_start_x/o_start_y/o_end_x/o_end_y  out  MAX_STROKES×cell width, flattened, entry k at slice k
- o_overflow  out  1  sticky: a stroke beyond MAX_STROKES was detected
- o_req  out  1  bitmap frozen, recogniser may sample
- i_result_valid  in  1  recogniser result strobe
- i_result  in  RES_W  recogniser class
- o_result  out  RES_W  latched class
- o_result_valid  out  1  result held and displayable

## Operation
- States: IDLE, CAPTURE, CHECK, WAIT, SHOW.
- IDLE: grid, stroke table, count, overflow, result and last point all cleared. i_session=1 goes to CAPTURE.
- CAPTURE: each i_touch_valid sets grid bit (cx,cy) and updates the end point of the current stroke to (cx,cy).
  - The first sample after IDLE opens stroke 0 with start=end=(cx,cy) and sets count=1.
  - A later sample opens a new stroke when |cx-last_x|>1, or |cy-last_y|>1, or (SPLIT_ON_LIFT and i_touch_valid was low on the previous cycle).
  - When a new stroke would exceed MAX_STROKES: set o_overflow, and the sample extends the last stroke (end only).
  - i_session=0 goes to CHECK if count>0, otherwise to IDLE.
- CHECK: one cycle with everything frozen, then WAIT.
- WAIT: o_req=1. i_result_valid latches i_result and goes to SHOW.
- SHOW: o_req=1, o_result_valid=1. Holds until i_clear.
- Priority: i_clear > all. i_touch_valid outside CAPTURE is ignored. i_result_valid outside WAIT is ignored.
- If a valid sample arrives in the same cycle i_session falls, the sample is captured, then the state goes to CHECK.
- Widths:
  - Mapping products use COORD_W+$clog2(MUL+1) bits.
  - Deltas are computed as unsigned absolute differences of cell indices.
  - Clamping is applied before any use.

## Timing
- Reset: state IDLE. All registered outputs are 0: o_grid, stroke table, o_stroke_count, o_overflow, o_req, o_result, o_result_valid.
- o_cell_x/o_cell_y are combinational (zero latency).
- A sample in cycle n is visible in o_grid and the stroke table in cycle n+1.
- i_session falling at cycle n: CHECK at n+1, o_req high from n+2.
- i_result_valid at cycle m in WAIT: o_result and o_result_valid valid at m+1.
- i_clear at cycle n: IDLE at n+1 with all outputs zero. i_session must be high in IDLE for CAPTURE to start at n+2 at the earliest.
- Async reset mid-operation: immediate return to reset values.

## Structure
- Package stroke_grid_pkg holds:
  - state_t enum
  - cell point struct (x,y)
  - a helper function for the adjacency test
- Sub-module coord_scaler (multiply, shift, clamp; parametrised MUL/SHIFT/CELLS) is instantiated once per axis.
- The remaining logic lives in one FSM plus the datapath registers.

## Test plan
- Defaults: session on, valid at (2048,2048) -> o_cell=(6,4), next cycle o_grid bit 52 set, count=1, start=end=(6,4).
- Continuous drag (0,0)->(1023,511)->(1400,1000) (cells (0,0),(2,0),(4,1)): a gap of 2 triggers a new stroke -> count=3; stroke1 start (2,0), stroke0 end (0,0).
- SPLIT_ON_LIFT=1: touch (6,4), one idle cycle, touch (6,5) -> count=2. With SPLIT_ON_LIFT=0 the same stimulus gives count=1, end=(6,5).
- MAX_STROKES=2: five widely separated taps -> count=2, o_overflow=1, stroke1 end = last tap cell.
- Handshake: session drop at n -> o_req at n+2. i_result_valid=1 with i_result=7 -> o_result=7 and o_result_valid=1 next cycle, held until i_clear, then all zero.
- GRID_W=10: x=4095 -> o_cell_x=9 (clamped). Session ending with no touches -> IDLE and o_req never asserted.
